// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// fault cause codes and the idle/fault NOP instruction word.
package inst_fetch_pkg;

  typedef enum logic [2:0] {
    IFU_IDLE    = 3'd0,
    IFU_REQ     = 3'd1,
    IFU_WAIT    = 3'd2,
    IFU_DELIVER = 3'd3,
    IFU_FAULT   = 3'd4
  } ifu_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_TIMEOUT  = 2'b10,
    CAUSE_BUS_ERR  = 2'b11
  } fault_cause_e;

  // addi x0,x0,0
  localparam logic [31:0] IFU_NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction memory read bus: request channel (valid/ready) plus a
// single-beat response channel qualified by mem_resp_valid.
interface inst_fetch_if;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        mem_resp_err;

  modport master (
    output mem_req_valid,
    output mem_req_addr,
    input  mem_req_ready,
    input  mem_resp_valid,
    input  mem_resp_data,
    input  mem_resp_err
  );

  modport slave (
    input  mem_req_valid,
    input  mem_req_addr,
    output mem_req_ready,
    output mem_resp_valid,
    output mem_resp_data,
    output mem_resp_err
  );

endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: one outstanding read per PC, buffered result
// handed to the core over valid/ready, misaligned/timeout/bus faults reported.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter int          CNT_W    = 8,
  parameter logic [31:0] NOP_INST = IFU_NOP_INST
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pc,
  output logic [31:0]         inst,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic                inst_fault,
  output logic [1:0]          fault_cause,
  inst_fetch_if.master        mem,
  output logic [31:0]         fetch_count
);

  ifu_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  data_q, data_d;
  logic         req_vld_q, req_vld_d;
  logic         inst_vld_q, inst_vld_d;
  logic         fault_q, fault_d;
  fault_cause_e cause_q, cause_d;
  logic [31:0]  fcnt_q, fcnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IFU_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= NOP_INST;
      req_vld_q  <= 1'b0;
      inst_vld_q <= 1'b0;
      fault_q    <= 1'b0;
      cause_q    <= CAUSE_NONE;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      req_vld_q  <= req_vld_d;
      inst_vld_q <= inst_vld_d;
      fault_q    <= fault_d;
      cause_q    <= cause_d;
      fcnt_q     <= fcnt_d;
    end
  end

  // Next-state logic also computes the next value of every output register,
  // so all outputs change only on the clock edge that enters a state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    req_vld_d  = req_vld_q;
    inst_vld_d = inst_vld_q;
    fault_d    = fault_q;
    cause_d    = cause_q;
    fcnt_d     = fcnt_q;

    unique case (state_q)
      IFU_IDLE: begin
        addr_d = {pc[31:2], 2'b00};
        if (pc[1:0] != 2'b00) begin
          state_d    = IFU_FAULT;
          inst_vld_d = 1'b1;
          fault_d    = 1'b1;
          cause_d    = CAUSE_MISALIGN;
          data_d     = NOP_INST;
        end else begin
          state_d   = IFU_REQ;
          req_vld_d = 1'b1;
        end
      end

      IFU_REQ: begin
        if (mem.mem_req_ready) begin
          state_d   = IFU_WAIT;
          req_vld_d = 1'b0;
          cnt_d     = '0;
        end
      end

      IFU_WAIT: begin
        // A response seen together with the last counted cycle beats the timeout.
        if (mem.mem_resp_valid) begin
          inst_vld_d = 1'b1;
          if (mem.mem_resp_err) begin
            state_d = IFU_FAULT;
            fault_d = 1'b1;
            cause_d = CAUSE_BUS_ERR;
            data_d  = NOP_INST;
          end else begin
            state_d = IFU_DELIVER;
            data_d  = mem.mem_resp_data;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d    = IFU_FAULT;
          inst_vld_d = 1'b1;
          fault_d    = 1'b1;
          cause_d    = CAUSE_TIMEOUT;
          data_d     = NOP_INST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      IFU_DELIVER: begin
        if (inst_ready) begin
          state_d    = IFU_IDLE;
          inst_vld_d = 1'b0;
          data_d     = NOP_INST;
          fcnt_d     = fcnt_q + 32'd1;
        end
      end

      IFU_FAULT: begin
        if (inst_ready) begin
          state_d    = IFU_IDLE;
          inst_vld_d = 1'b0;
          fault_d    = 1'b0;
          cause_d    = CAUSE_NONE;
          data_d     = NOP_INST;
        end
      end

      default: begin
        state_d    = IFU_IDLE;
        req_vld_d  = 1'b0;
        inst_vld_d = 1'b0;
        fault_d    = 1'b0;
        cause_d    = CAUSE_NONE;
        data_d     = NOP_INST;
      end
    endcase
  end

  assign inst              = data_q;
  assign inst_valid        = inst_vld_q;
  assign inst_fault        = fault_q;
  assign fault_cause       = cause_q;
  assign mem.mem_req_valid = req_vld_q;
  assign mem.mem_req_addr  = addr_q;
  assign fetch_count       = fcnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: table of fetch transactions against a
// cycle-stepped memory model, plus reset-state and reset-mid-WAIT sequences.
module tb_inst_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;
  logic        inst_fault;
  logic [1:0]  fault_cause;
  logic [31:0] fetch_count;

  inst_fetch_if bus();

  inst_fetch #(.TIMEOUT(255), .CNT_W(8), .NOP_INST(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_fault  (inst_fault),
    .fault_cause (fault_cause),
    .mem         (bus),
    .fetch_count (fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          stall;     // extra REQ cycles before mem_req_ready
    int          lat;       // response arrives in the lat-th WAIT cycle
    bit          no_resp;
    bit          err;
    logic [31:0] data;
    int          rdy_dly;   // valid cycles with inst_ready low
    bit          stray;     // spurious response during IDLE and first REQ cycle
    bit          exp_req;
    bit          exp_fault;
    logic [1:0]  exp_cause;
    logic [31:0] exp_inst;
    int          exp_lat;   // cycles from IDLE to first inst_valid
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_cnt = '0;
  vec_t        vecs[10];

  function automatic vec_t mk(input logic [31:0] p, input int st, input int lt,
                              input bit nr, input bit er, input logic [31:0] d,
                              input int rd, input bit sy, input bit ereq,
                              input bit ef, input logic [1:0] ec,
                              input logic [31:0] ei, input int el);
    vec_t v;
    v.pc = p; v.stall = st; v.lat = lt; v.no_resp = nr; v.err = er; v.data = d;
    v.rdy_dly = rd; v.stray = sy; v.exp_req = ereq; v.exp_fault = ef;
    v.exp_cause = ec; v.exp_inst = ei; v.exp_lat = el;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " inst"},          inst,                   NOP);
    chk({tag, " inst_valid"},    32'(inst_valid),        32'd0);
    chk({tag, " inst_fault"},    32'(inst_fault),        32'd0);
    chk({tag, " fault_cause"},   32'(fault_cause),       32'd0);
    chk({tag, " mem_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
    chk({tag, " mem_req_addr"},  bus.mem_req_addr,       32'd0);
    chk({tag, " fetch_count"},   fetch_count,            32'd0);
  endtask

  // Starts in an IDLE cycle (#1 after an edge) and ends #1 after the handshake edge.
  task automatic run_fetch(input int idx, input vec_t v);
    bit          accepted = 0, req_seen = 0, got = 0, stable = 1, hs = 0;
    bit          acc_now, hs_now;
    int          wait_cyc = 0, vcyc = 0, lat_seen = -1;
    logic [31:0] first_inst = '0;
    logic        first_fault = 1'b0;
    logic [1:0]  first_cause = '0;
    string       t;
    t = $sformatf("v%0d", idx);
    pc = v.pc;
    for (int c = 0; c < 600 && !hs; c++) begin
      bus.mem_req_ready  = (c >= v.stall + 1);
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_err   = 1'b0;
      bus.mem_resp_data  = '0;
      if (v.stray && c < 2) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_err   = 1'b1;
        bus.mem_resp_data  = 32'hdead_beef;
      end
      if (accepted && !v.no_resp && wait_cyc == v.lat) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_err   = v.err;
        bus.mem_resp_data  = v.data;
      end
      if (bus.mem_req_valid) begin
        req_seen = 1;
        chk({t, " mem_req_addr"}, bus.mem_req_addr, {v.pc[31:2], 2'b00});
      end
      if (inst_valid && !got) begin
        got = 1; lat_seen = c;
        first_inst = inst; first_fault = inst_fault; first_cause = fault_cause;
      end
      if (inst_valid && (inst !== first_inst || inst_fault !== first_fault ||
                         fault_cause !== first_cause))
        stable = 0;
      inst_ready = inst_valid && (vcyc >= v.rdy_dly);
      if (inst_valid) vcyc++;
      acc_now = bus.mem_req_valid && bus.mem_req_ready;
      hs_now  = inst_valid && inst_ready;
      @(posedge clk); #1;
      if (accepted) wait_cyc++;
      if (acc_now) begin accepted = 1; wait_cyc = 1; end
      if (hs_now) hs = 1;
    end
    inst_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_req_ready  = 1'b0;
    if (!hs) begin
      checks++; errors++;
      $display("FAIL %s handshake: none within 600 cycles, required one", t);
    end
    if (!v.exp_fault) exp_cnt++;
    chk({t, " req_issued"},  32'(req_seen),    32'(v.exp_req));
    chk({t, " latency"},     32'(lat_seen),    32'(v.exp_lat));
    chk({t, " inst"},        first_inst,       v.exp_inst);
    chk({t, " inst_fault"},  32'(first_fault), 32'(v.exp_fault));
    chk({t, " fault_cause"}, 32'(first_cause), 32'(v.exp_cause));
    chk({t, " stable"},      32'(stable),      32'd1);
    chk({t, " fetch_count"}, fetch_count,      exp_cnt);
    chk({t, " valid_after"}, 32'(inst_valid),  32'd0);
    chk({t, " inst_after"},  inst,             NOP);
  endtask

  initial begin
    //           pc            st  lat  nr err data           rdy sy req flt cause inst           lat
    vecs[0] = mk(32'h80000000, 0,   1, 0, 0, 32'h00500093, 0, 0, 1, 0, 2'b00, 32'h00500093,   3);
    vecs[1] = mk(32'h80000004, 0,   5, 0, 0, 32'h00a00113, 4, 0, 1, 0, 2'b00, 32'h00a00113,   7);
    vecs[2] = mk(32'h80000002, 0,   1, 0, 0, 32'h0,        0, 0, 0, 1, 2'b01, NOP,            1);
    vecs[3] = mk(32'h80000008, 0,   1, 1, 0, 32'h0,        2, 0, 1, 1, 2'b10, NOP,          258);
    vecs[4] = mk(32'h8000000c, 0,   1, 0, 0, 32'h002081b3, 0, 1, 1, 0, 2'b00, 32'h002081b3,   3);
    vecs[5] = mk(32'h80000010, 0,   2, 0, 1, 32'h12345678, 1, 0, 1, 1, 2'b11, NOP,            4);
    vecs[6] = mk(32'h80000014, 3, 256, 0, 0, 32'h00308213, 0, 0, 1, 0, 2'b00, 32'h00308213, 261);
    vecs[7] = mk(32'h80000018, 0, 255, 0, 0, 32'h00410293, 0, 0, 1, 0, 2'b00, 32'h00410293, 257);
    vecs[8] = mk(32'h80000001, 0,   1, 0, 0, 32'h0,        0, 0, 0, 1, 2'b01, NOP,            1);
    vecs[9] = mk(32'h80000020, 0,   1, 0, 0, 32'h00000297, 0, 1, 1, 0, 2'b00, 32'h00000297,   3);

    rst = 1'b1; pc = '0; inst_ready = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_resp_valid = 1'b0;
    bus.mem_resp_err = 1'b0; bus.mem_resp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_fetch(i, vecs[i]);

    // Reset taken in WAIT while a response is on the bus: reset must win.
    pc = 32'h80000100;
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mem_req_ready  = 1'b0;
    rst                = 1'b1;
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_err   = 1'b0;
    bus.mem_resp_data  = 32'h11111111;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.mem_resp_valid = 1'b0;
    exp_cnt = '0;
    chk_reset_state("rst_wait");
    run_fetch(9, vecs[9]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
